int_rs: RTL

Integer reservation station for the out-of-order backend. Buffers integer ALU uops from dispatch and captures source operands from dispatch or from CDB wakeup. Each cycle it selects the oldest uop whose operands are both ready and issues it into the registered `int_rs_reg` / `int_rs_reg_valid` pair consumed by `fu_alu`. The station is value-capturing: issued uops carry final `rs1_value` / `rs2_value`, so there is no register-file read after issue.

---
 rtl/int_rs_pkg.sv | 65 ++++++
 rtl/cdb_itf.sv | 10 +
 rtl/int_rs_age_matrix.sv | 36 +++
 rtl/int_rs.sv | 116 +++++++++++
 4 files changed

// File: rtl/int_rs_pkg.sv
// rtl/int_rs_pkg.sv - shared widths and uop types for the integer reservation station
package int_rs_pkg;

   localparam int DEFAULT_INT_RS_DEPTH = 8;
   localparam int ROB_IDX_W  = 5;
   localparam int PRF_IDX_W  = 6;
   localparam int ARCH_REG_W = 5;
   localparam int XLEN       = 32;
   localparam int IMM_W      = 20;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
      ALU_SLT, ALU_SLTU, ALU_LUI, ALU_AUIPC
   } alu_op_e;

   typedef enum logic { OP1_RS1, OP1_PC  } op1_sel_e;
   typedef enum logic { OP2_RS2, OP2_IMM } op2_sel_e;

   typedef struct packed {
      alu_op_e                fu_opcode;
      op1_sel_e               op1_sel;
      op2_sel_e               op2_sel;
      logic [IMM_W-1:0]       imm_packed;
      logic [XLEN-1:0]        pc;
      logic [ROB_IDX_W-1:0]   rob_id;
      logic [ARCH_REG_W-1:0]  rd_arch;
      logic [PRF_IDX_W-1:0]   rd_phy;
      logic [PRF_IDX_W-1:0]   rs1_phy;
      logic [XLEN-1:0]        rs1_value;
      logic                   rs1_rdy;
      logic [PRF_IDX_W-1:0]   rs2_phy;
      logic [XLEN-1:0]        rs2_value;
      logic                   rs2_rdy;
   } int_rs_entry_t;

   typedef struct packed {
      alu_op_e                fu_opcode;
      op1_sel_e               op1_sel;
      op2_sel_e               op2_sel;
      logic [IMM_W-1:0]       imm_packed;
      logic [XLEN-1:0]        pc;
      logic [ROB_IDX_W-1:0]   rob_id;
      logic [ARCH_REG_W-1:0]  rd_arch;
      logic [PRF_IDX_W-1:0]   rd_phy;
      logic [XLEN-1:0]        rs1_value;
      logic [XLEN-1:0]        rs2_value;
   } int_rs_reg_t;

   // Operands are already captured, so issue is a plain field copy.
   function automatic int_rs_reg_t to_issue(input int_rs_entry_t e);
      int_rs_reg_t r;
      r.fu_opcode  = e.fu_opcode;
      r.op1_sel    = e.op1_sel;
      r.op2_sel    = e.op2_sel;
      r.imm_packed = e.imm_packed;
      r.pc         = e.pc;
      r.rob_id     = e.rob_id;
      r.rd_arch    = e.rd_arch;
      r.rd_phy     = e.rd_phy;
      r.rs1_value  = e.rs1_value;
      r.rs2_value  = e.rs2_value;
      return r;
   endfunction

endpackage

// File: rtl/cdb_itf.sv
// rtl/cdb_itf.sv - common data bus broadcast of one completed result per cycle
interface cdb_itf
   import int_rs_pkg::*;
();
   logic                 valid;
   logic [PRF_IDX_W-1:0] rd_phy;
   logic [XLEN-1:0]      rd_value;

   modport rs (input valid, input rd_phy, input rd_value);
endinterface

// File: rtl/int_rs_age_matrix.sv
// rtl/int_rs_age_matrix.sv - age matrix granting the oldest requesting entry
module int_rs_age_matrix #(
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DEPTH-1:0] alloc,
   input  logic [DEPTH-1:0] free,
   input  logic [DEPTH-1:0] req,
   output logic [DEPTH-1:0] grant
);

   // older_q[i][j] set means entry j was allocated before entry i.
   logic [DEPTH-1:0] older_q [DEPTH];
   logic [DEPTH-1:0] occ_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         occ_q <= '0;
         for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
      end else begin
         occ_q <= (occ_q & ~free) | alloc;
         for (int i = 0; i < DEPTH; i++) begin
            if (alloc[i]) older_q[i] <= occ_q & ~free & ~alloc;
            else          older_q[i] <= older_q[i] & ~alloc;
         end
      end
   end

   always_comb begin
      grant = '0;
      for (int i = 0; i < DEPTH; i++)
         grant[i] = req[i] && ((req & older_q[i]) == '0);
   end

endmodule

// File: rtl/int_rs.sv
// rtl/int_rs.sv - value-capturing integer reservation station with oldest-ready issue
module int_rs
   import int_rs_pkg::*;
#(
   parameter int INT_RS_DEPTH = DEFAULT_INT_RS_DEPTH
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          dispatch_valid,
   output logic          dispatch_ready,
   input  int_rs_entry_t dispatch_uop,
   cdb_itf.rs            cdb,
   input  logic          fu_ready,
   output int_rs_reg_t   int_rs_reg,
   output logic          int_rs_reg_valid
);

   int_rs_entry_t           ent_q [INT_RS_DEPTH];
   logic [INT_RS_DEPTH-1:0] valid_q;
   logic [INT_RS_DEPTH-1:0] req;
   logic [INT_RS_DEPTH-1:0] grant;
   logic [INT_RS_DEPTH-1:0] free_slot;
   logic [INT_RS_DEPTH-1:0] alloc_oh;
   logic [INT_RS_DEPTH-1:0] issue_oh;
   logic [INT_RS_DEPTH-1:0] free_oh;
   logic                    do_alloc;
   logic                    do_issue;
   logic                    found;
   int_rs_entry_t           new_ent;
   int_rs_reg_t             sel_reg;

   assign dispatch_ready = ~&valid_q;
   assign do_alloc       = dispatch_valid && dispatch_ready && !flush;
   assign do_issue       = fu_ready && (|req) && !flush;
   assign issue_oh       = do_issue ? grant : '0;
   assign alloc_oh       = do_alloc ? free_slot : '0;
   assign free_oh        = flush ? '1 : issue_oh;

   always_comb begin
      free_slot = '0;
      found     = 1'b0;
      for (int i = 0; i < INT_RS_DEPTH; i++) begin
         req[i] = valid_q[i] && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy;
         if (!valid_q[i] && !found) begin
            free_slot[i] = 1'b1;
            found        = 1'b1;
         end
      end
   end

   // A source broadcast in the dispatch cycle is captured on the way in.
   always_comb begin
      new_ent = dispatch_uop;
      if (cdb.valid && !dispatch_uop.rs1_rdy && dispatch_uop.rs1_phy == cdb.rd_phy) begin
         new_ent.rs1_value = cdb.rd_value;
         new_ent.rs1_rdy   = 1'b1;
      end
      if (cdb.valid && !dispatch_uop.rs2_rdy && dispatch_uop.rs2_phy == cdb.rd_phy) begin
         new_ent.rs2_value = cdb.rd_value;
         new_ent.rs2_rdy   = 1'b1;
      end
   end

   always_comb begin
      sel_reg = '0;
      for (int i = 0; i < INT_RS_DEPTH; i++)
         if (grant[i]) sel_reg = to_issue(ent_q[i]);
   end

   int_rs_age_matrix #(.DEPTH(INT_RS_DEPTH)) u_age (
      .clk   (clk),
      .rst   (rst),
      .alloc (alloc_oh),
      .free  (free_oh),
      .req   (req),
      .grant (grant)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)       valid_q <= '0;
      else if (flush) valid_q <= '0;
      else            valid_q <= (valid_q & ~issue_oh) | alloc_oh;
   end

   // Payload needs no reset: valid_q gates every use of it.
   always_ff @(posedge clk) begin
      for (int i = 0; i < INT_RS_DEPTH; i++) begin
         if (alloc_oh[i]) begin
            ent_q[i] <= new_ent;
         end else if (valid_q[i] && cdb.valid) begin
            if (!ent_q[i].rs1_rdy && ent_q[i].rs1_phy == cdb.rd_phy) begin
               ent_q[i].rs1_value <= cdb.rd_value;
               ent_q[i].rs1_rdy   <= 1'b1;
            end
            if (!ent_q[i].rs2_rdy && ent_q[i].rs2_phy == cdb.rd_phy) begin
               ent_q[i].rs2_value <= cdb.rd_value;
               ent_q[i].rs2_rdy   <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         int_rs_reg       <= '0;
         int_rs_reg_valid <= 1'b0;
      end else if (flush) begin
         int_rs_reg_valid <= 1'b0;
      end else begin
         int_rs_reg_valid <= do_issue;
         if (do_issue) int_rs_reg <= sel_reg;
      end
   end

endmodule
